process2_monitor_ctrl: RTL and testbench



---
 rtl/process2_monitor_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_process2_monitor_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/process2_monitor_ctrl.sv
// process2_monitor_ctrl: initiator-side sequencer for the process monitor 2 macro.
// Optional build macro PM_CTRL_SKIP_UNUSED_EN drains only channels whose use_ro bit is set.
module process2_monitor_ctrl #(
  parameter int NB_MONITOR    = 43,
  parameter int COUNT_W       = 16,
  parameter int TARGET_W      = 4,
  parameter int TIMEOUT_W     = 24,
  parameter int SETTLE_CYCLES = 2,
  parameter int COOL_CYCLES   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [TARGET_W-1:0]           req_target,
  input  logic [NB_MONITOR-1:0]         req_use,
  input  logic [TIMEOUT_W-1:0]          cfg_timeout,
  output logic                          pm_enable,
  output logic [TARGET_W-1:0]           pm_target,
  output logic [NB_MONITOR-1:0]         pm_use_ro,
  input  logic                          pm_valid,
  input  logic [NB_MONITOR*COUNT_W-1:0] pm_count,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(NB_MONITOR)-1:0] res_idx,
  output logic [COUNT_W-1:0]            res_count,
  output logic                          res_last,
  output logic                          res_err,
  output logic                          busy
);
  localparam int IDX_W = $clog2(NB_MONITOR);
  localparam logic [TIMEOUT_W-1:0] SETTLE_LAST = TIMEOUT_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] COOL_LAST   = TIMEOUT_W'(COOL_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, ERR, COOL} state_t;

  state_t                  state_q, state_d;
  logic [TIMEOUT_W-1:0]    cnt_q, cnt_d;
  logic                    req_ready_q, req_ready_d;
  logic                    busy_q, busy_d;
  logic                    pm_enable_q, pm_enable_d;
  logic [TARGET_W-1:0]     pm_target_q, pm_target_d;
  logic [NB_MONITOR-1:0]   use_q, use_d;
  logic [COUNT_W-1:0]      snap_q [NB_MONITOR];
  logic [COUNT_W-1:0]      snap_d [NB_MONITOR];
  logic                    res_valid_q, res_valid_d;
  logic [IDX_W-1:0]        res_idx_q, res_idx_d;
  logic [COUNT_W-1:0]      res_count_q, res_count_d;
  logic                    res_last_q, res_last_d;
  logic                    res_err_q, res_err_d;
  logic [IDX_W-1:0]        first_idx, next_idx, last_idx;

`ifdef PM_CTRL_SKIP_UNUSED_EN
  logic found_first, found_next;

  // next_idx is the lowest used channel strictly above the beat currently presented
  always_comb begin
    first_idx   = '0;
    next_idx    = '0;
    last_idx    = '0;
    found_first = 1'b0;
    found_next  = 1'b0;
    for (int unsigned i = 0; i < NB_MONITOR; i++) begin
      if (use_q[i]) begin
        last_idx = IDX_W'(i);
        if (!found_first) begin
          first_idx   = IDX_W'(i);
          found_first = 1'b1;
        end
        if (!found_next && (IDX_W'(i) > res_idx_q)) begin
          next_idx   = IDX_W'(i);
          found_next = 1'b1;
        end
      end
    end
  end
`else
  assign first_idx = '0;
  assign last_idx  = IDX_W'(NB_MONITOR - 1);
  assign next_idx  = res_idx_q + IDX_W'(1);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pm_target_d = pm_target_q;
    use_d       = use_q;
    snap_d      = snap_q;
    res_valid_d = res_valid_q;
    res_idx_d   = res_idx_q;
    res_count_d = res_count_q;
    res_last_d  = res_last_q;
    res_err_d   = res_err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          pm_target_d = req_target;
          use_d       = req_use;
          cnt_d       = '0;
          if (req_use == '0) begin
            state_d     = ERR;
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
            res_idx_d   = '0;
            res_count_d = '0;
            res_last_d  = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      RUN: begin
        if (pm_valid) begin
          for (int unsigned i = 0; i < NB_MONITOR; i++) begin
            snap_d[i] = pm_count[i*COUNT_W +: COUNT_W];
          end
          state_d     = DRAIN;
          res_valid_d = 1'b1;
          res_err_d   = 1'b0;
          res_idx_d   = first_idx;
          res_count_d = snap_d[first_idx];
          res_last_d  = (first_idx == last_idx);
        end else if ((cfg_timeout != '0) && (cnt_q == cfg_timeout - TIMEOUT_W'(1))) begin
          state_d     = ERR;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          res_idx_d   = '0;
          res_count_d = '0;
          res_last_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      DRAIN: begin
        if (res_valid_q && res_ready) begin
          if (res_last_q) begin
            state_d     = COOL;
            cnt_d       = '0;
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
          end else begin
            res_idx_d   = next_idx;
            res_count_d = snap_q[next_idx];
            res_last_d  = (next_idx == last_idx);
          end
        end
      end
      ERR: begin
        if (res_valid_q && res_ready) begin
          state_d     = COOL;
          cnt_d       = '0;
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          res_err_d   = 1'b0;
        end
      end
      COOL: begin
        if (cnt_q == COOL_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    pm_enable_d = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      pm_enable_q <= 1'b0;
      pm_target_q <= '0;
      use_q       <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_count_q <= '0;
      res_last_q  <= 1'b0;
      res_err_q   <= 1'b0;
      for (int unsigned i = 0; i < NB_MONITOR; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      pm_enable_q <= pm_enable_d;
      pm_target_q <= pm_target_d;
      use_q       <= use_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_count_q <= res_count_d;
      res_last_q  <= res_last_d;
      res_err_q   <= res_err_d;
      snap_q      <= snap_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign pm_enable = pm_enable_q;
  assign pm_target = pm_target_q;
  assign pm_use_ro = use_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_count = res_count_q;
  assign res_last  = res_last_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_process2_monitor_ctrl.sv
// Directed bench for process2_monitor_ctrl with a stub monitor that raises valid a set number of cycles after enable.
module tb_process2_monitor_ctrl;
  localparam int NB = 43;
  localparam int CW = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_target;
  logic [NB-1:0]    req_use;
  logic [23:0]      cfg_timeout;
  logic             pm_enable;
  logic [3:0]       pm_target;
  logic [NB-1:0]    pm_use_ro;
  logic             pm_valid;
  logic [NB*CW-1:0] pm_count;
  logic             res_valid;
  logic             res_ready;
  logic [5:0]       res_idx;
  logic [CW-1:0]    res_count;
  logic             res_last;
  logic             res_err;
  logic             busy;

  logic [NB*CW-1:0] mon_cnt;
  logic             mon_never;
  int               mon_delay;
  int               en_cnt;

  int total = 0;
  int bad   = 0;
  int got_n, exp_n, lat, hi;
  int got_idx [64];
  int got_cnt [64];
  int got_last[64];
  int got_err [64];
  int exp_idx [64];
  int exp_cnt [64];
  logic [NB-1:0] all_m, sparse_m;

  process2_monitor_ctrl #(
    .NB_MONITOR(NB), .COUNT_W(CW), .TARGET_W(4), .TIMEOUT_W(24),
    .SETTLE_CYCLES(2), .COOL_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_target(req_target), .req_use(req_use),
    .cfg_timeout(cfg_timeout),
    .pm_enable(pm_enable), .pm_target(pm_target), .pm_use_ro(pm_use_ro),
    .pm_valid(pm_valid), .pm_count(pm_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_count(res_count),
    .res_last(res_last), .res_err(res_err), .busy(busy)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (!pm_enable) en_cnt <= 0;
    else            en_cnt <= en_cnt + 1;
  end
  assign pm_valid = pm_enable && !mon_never && (en_cnt >= mon_delay);
  assign pm_count = mon_cnt;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_mon(input logic [NB-1:0] use_m, input int base);
    for (int i = 0; i < NB; i++) begin
      mon_cnt[i*CW +: CW] = use_m[i] ? CW'(base + i) : '0;
    end
  endtask

  // Returns at the negedge of the cycle after the accept; request fields are then scrambled.
  task automatic send_req(input logic [3:0] tgt, input logic [NB-1:0] use_m);
    int g;
    req_valid  = 1'b1;
    req_target = tgt;
    req_use    = use_m;
    g = 0;
    while (!req_ready && g < 200) begin
      @(negedge clock);
      g++;
    end
    check("req_ready_wait", g < 200, 1);
    @(negedge clock);
    req_valid  = 1'b0;
    req_target = ~tgt;
    req_use    = ~use_m;
  endtask

  task automatic measure();
    lat = 1;
    while (!pm_enable && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    hi = 0;
    while (pm_enable && hi < 2000) begin
      @(negedge clock);
      hi++;
    end
  endtask

  task automatic drain(input int mode);
    int cyc, en_seen, unstable;
    logic done, stalled, p_last, p_err;
    logic [5:0] p_idx;
    logic [CW-1:0] p_cnt;
    got_n = 0; cyc = 0; en_seen = 0; unstable = 0;
    done = 1'b0; stalled = 1'b0;
    p_idx = '0; p_cnt = '0; p_last = 1'b0; p_err = 1'b0;
    while (!done && cyc < 2000) begin
      if (pm_enable) en_seen++;
      if (stalled && (!res_valid || res_idx !== p_idx || res_count !== p_cnt ||
                      res_last !== p_last || res_err !== p_err)) unstable++;
      res_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (res_valid && res_ready) begin
        if (got_n < 64) begin
          got_idx[got_n]  = int'(res_idx);
          got_cnt[got_n]  = int'(res_count);
          got_last[got_n] = int'(res_last);
          got_err[got_n]  = int'(res_err);
        end
        got_n++;
        if (res_last) done = 1'b1;
        stalled = 1'b0;
      end else begin
        stalled = res_valid;
        p_idx = res_idx; p_cnt = res_count; p_last = res_last; p_err = res_err;
      end
      @(negedge clock);
      cyc++;
    end
    res_ready = 1'b0;
    check("drain_done", done, 1);
    check("drain_enable_low", en_seen, 0);
    check("drain_payload_stable", unstable, 0);
  endtask

  task automatic check_beats(input string nm, input logic [NB-1:0] use_m, input int base, input bit err_beat);
    exp_n = 0;
    if (err_beat) begin
      exp_idx[0] = 0; exp_cnt[0] = 0; exp_n = 1;
    end else begin
      for (int i = 0; i < NB; i++) begin
`ifdef PM_CTRL_SKIP_UNUSED_EN
        if (use_m[i]) begin
`else
        begin
`endif
          exp_idx[exp_n] = i;
          exp_cnt[exp_n] = use_m[i] ? base + i : 0;
          exp_n++;
        end
      end
    end
    check({nm, "_nbeats"}, got_n, exp_n);
    for (int k = 0; k < exp_n && k < got_n && k < 64; k++) begin
      check($sformatf("%s_b%0d_idx", nm, k),  got_idx[k],  exp_idx[k]);
      check($sformatf("%s_b%0d_cnt", nm, k),  got_cnt[k],  exp_cnt[k]);
      check($sformatf("%s_b%0d_last", nm, k), got_last[k], (k == exp_n - 1) ? 1 : 0);
      check($sformatf("%s_b%0d_err", nm, k),  got_err[k],  err_beat ? 1 : 0);
    end
  endtask

  task automatic cool_check(input string nm);
    int c, en;
    c = 0; en = 0;
    check({nm, "_res_valid_after"}, res_valid, 0);
    while (!req_ready && c < 100) begin
      if (pm_enable) en++;
      @(negedge clock);
      c++;
    end
    check({nm, "_cool_cycles"}, c, 4);
    check({nm, "_cool_enable_low"}, en, 0);
    check({nm, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int hs, g;
    req_valid = 1'b0; req_target = '0; req_use = '0; cfg_timeout = '0; res_ready = 1'b0;
    mon_never = 1'b1; mon_delay = 0; mon_cnt = '0;
    all_m = '1;
    sparse_m = '0; sparse_m[2] = 1'b1; sparse_m[7] = 1'b1; sparse_m[40] = 1'b1;

    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_pm_enable", pm_enable, 0);
    check("rst_pm_target", pm_target, 0);
    check("rst_pm_use_ro", pm_use_ro, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_fields", {res_idx, res_count, res_last, res_err}, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_release_ready", req_ready, 1);

    // basic measurement
    set_mon(all_m, 100); mon_never = 1'b0; mon_delay = 20; cfg_timeout = '0;
    send_req(4'd3, all_m);
    check("basic_pm_target", pm_target, 3);
    check("basic_pm_use_ro", pm_use_ro, all_m);
    check("basic_busy", busy, 1);
    check("basic_req_ready_low", req_ready, 0);
    measure();
    check("basic_enable_latency", lat, 3);
    check("basic_enable_len", hi, 21);
    check("basic_target_hold", pm_target, 3);
    drain(0);
    check_beats("basic", all_m, 100, 1'b0);
    cool_check("basic");

    // backpressure 1-0-0-1
    set_mon(all_m, 200); mon_delay = 20;
    send_req(4'd5, all_m);
    measure();
    check("bp_enable_latency", lat, 3);
    drain(1);
    check_beats("bp", all_m, 200, 1'b0);
    cool_check("bp");

    // timeout
    mon_never = 1'b1; cfg_timeout = 24'd50;
    send_req(4'd2, all_m);
    measure();
    check("to_enable_latency", lat, 3);
    check("to_enable_len", hi, 50);
    drain(1);
    check_beats("to", all_m, 0, 1'b1);
    cool_check("to");

    // pm_valid on the expiry cycle
    set_mon(all_m, 300); mon_never = 1'b0; mon_delay = 9; cfg_timeout = 24'd10;
    send_req(4'd1, all_m);
    measure();
    check("race_enable_len", hi, 10);
    drain(0);
    check_beats("race", all_m, 300, 1'b0);
    cool_check("race");

    // empty mask
    cfg_timeout = '0;
    send_req(4'd7, '0);
    check("empty_enable", pm_enable, 0);
    check("empty_res_valid", res_valid, 1);
    drain(0);
    check_beats("empty", '0, 0, 1'b1);
    cool_check("empty");

    // sparse mask
    set_mon(sparse_m, 500); mon_delay = 5;
    send_req(4'd6, sparse_m);
    check("sparse_pm_use_ro", pm_use_ro, sparse_m);
    measure();
    check("sparse_enable_len", hi, 6);
    drain(0);
    check_beats("sparse", sparse_m, 500, 1'b0);
    cool_check("sparse");

    // reset in the middle of DRAIN
    set_mon(all_m, 600); mon_delay = 3;
    send_req(4'd4, all_m);
    measure();
    res_ready = 1'b1;
    hs = 0; g = 0;
    while (hs < 10 && g < 200) begin
      if (res_valid) hs++;
      @(negedge clock);
      g++;
    end
    check("mid_beats_done", hs, 10);
    check("mid_res_idx", res_idx, 10);
    check("mid_res_count", res_count, 610);
    reset = 1'b1; res_ready = 1'b0;
    @(negedge clock);
    check("mid_rst_enable", pm_enable, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);
    check("mid_release_ready", req_ready, 1);
    check("mid_release_res_valid", res_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
